// File: rtl/div_if.sv
// div_if: divider request/result bundle between the EX stage and div_unit
// master (EX stage): drives start, hassign, a, b, flush; receives stall, valid, results
// slave  (div_unit): receives the request, drives stall, valid, quotient, remainder, div_by_zero
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             hassign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, hassign, a, b, flush,
        input  stall, valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, hassign, a, b, flush,
        output stall, valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU, remainder to HI, quotient to LO
// clk, rst_n (async, active low)
// bus.start/hassign/a/b/flush in; bus.stall (combinational), bus.valid (one-cycle pulse),
// bus.quotient, bus.remainder, bus.div_by_zero out (held until the next completed divide)
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic  clk,
    input logic  rst_n,
    div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvs;
    logic               q_neg, r_neg;
    logic [WIDTH-1:0]   quotient, remainder;
    logic               div_by_zero;
    logic               stall;
    logic               go, b_zero, last;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     trial;
    logic               ge;
    logic [WIDTH-1:0]   nxt_quo, nxt_rem;

    assign go     = bus.start && !bus.flush;
    assign b_zero = bus.b == '0;
    assign last   = cnt == CNT_W'(WIDTH - 1);
    assign abs_a  = (bus.hassign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b  = (bus.hassign && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // quo holds the unconsumed dividend bits on the left and shifts quotient bits in on the right
    assign trial   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    assign ge      = !trial[WIDTH];
    assign nxt_rem = ge ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign nxt_quo = {quo[WIDTH-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall   = go;
                state_d = go ? (b_zero ? DONE : BUSY) : IDLE;
            end
            BUSY: begin
                stall   = 1'b1;
                state_d = bus.flush ? IDLE : (last ? DONE : BUSY);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state_q == IDLE && go) begin
            if (b_zero) begin
                quotient    <= '1;
                remainder   <= bus.a;
                div_by_zero <= 1'b1;
            end else begin
                cnt   <= '0;
                quo   <= abs_a;
                rem   <= '0;
                dvs   <= abs_b;
                q_neg <= bus.hassign && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg <= bus.hassign && bus.a[WIDTH-1];
            end
        end else if (state_q == BUSY && !bus.flush) begin
            cnt <= cnt + 1'b1;
            quo <= nxt_quo;
            rem <= nxt_rem;
            if (last) begin
                quotient    <= q_neg ? -nxt_quo : nxt_quo;
                remainder   <= r_neg ? -nxt_rem : nxt_rem;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign bus.stall       = stall;
    assign bus.valid       = state_q == DONE && !bus.flush;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomised checks of div_unit latency, stall, flush, reset and results
module tb_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    div_if #(.WIDTH(32)) bus ();

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one divide and returns at the negedge where valid is seen (or the bound expires).
    // lat counts clock edges from the start edge inclusive; st counts sampled stall cycles.
    task automatic run_div(input logic sg, input logic [31:0] x, input logic [31:0] y,
                           output int lat, output int st);
        @(negedge clk);
        bus.start = 1'b1;
        bus.hassign = sg;
        bus.a = x;
        bus.b = y;
        #1;
        st = bus.stall ? 1 : 0;
        @(posedge clk);
        lat = 1;
        #1 bus.start = 1'b0;
        @(negedge clk);
        while (!bus.valid && lat < 100) begin
            if (bus.stall) st++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic watch_no_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.valid) seen++;
        end
    endtask

    initial begin
        int lat, st, seen;
        logic [31:0] ra, rb, eq, er;
        logic sg;
        longint sa, sb;
        bus.start = 1'b0;
        bus.hassign = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        #12;
        check("rst_valid", bus.valid, 0);
        check("rst_q", bus.quotient, 0);
        check("rst_r", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_stall", bus.stall, 0);
        @(negedge clk) rst_n = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, lat, st);
        check("divu_lat", lat, 33);
        check("divu_stall_cycles", st, 33);
        check("divu_valid", bus.valid, 1);
        check("divu_stall_in_valid", bus.stall, 0);
        check("divu_q", bus.quotient, 14);
        check("divu_r", bus.remainder, 2);
        check("divu_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        check("valid_one_cycle", bus.valid, 0);
        check("q_held", bus.quotient, 14);

        run_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, st);
        check("div_neg_q", bus.quotient, 32'hFFFFFFFD);
        check("div_neg_r", bus.remainder, 32'hFFFFFFFF);
        run_div(1'b0, 32'hFFFFFFF9, 32'd2, lat, st);
        check("divu_big_q", bus.quotient, 32'h7FFFFFFC);
        check("divu_big_r", bus.remainder, 1);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, st);
        check("div_ovf_q", bus.quotient, 32'h80000000);
        check("div_ovf_r", bus.remainder, 0);

        run_div(1'b1, 32'd5, 32'd0, lat, st);
        check("dbz_lat", lat, 1);
        check("dbz_stall_cycles", st, 1);
        check("dbz_q", bus.quotient, 32'hFFFFFFFF);
        check("dbz_r", bus.remainder, 5);
        check("dbz_flag", bus.div_by_zero, 1);
        run_div(1'b0, 32'd5, 32'd0, lat, st);
        check("dbzu_q", bus.quotient, 32'hFFFFFFFF);
        check("dbzu_flag", bus.div_by_zero, 1);

        // flush mid-divide: outputs keep the prior 9/3 result
        run_div(1'b0, 32'd9, 32'd3, lat, st);
        check("prior_q", bus.quotient, 3);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush_stall", bus.stall, 0);
        check("flush_valid", bus.valid, 0);
        watch_no_valid(40, seen);
        check("flush_no_valid", seen, 0);
        check("flush_q_kept", bus.quotient, 3);
        check("flush_r_kept", bus.remainder, 0);

        // flush together with start in IDLE: ignored
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1;
        #1 check("flush_start_stall", bus.stall, 0);
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
        @(negedge clk);
        check("flush_start_idle", bus.stall, 0);

        // start while busy with different operands must not reload
        @(negedge clk);
        bus.start = 1'b1; bus.hassign = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        #1 begin bus.a = 32'd9; bus.b = 32'd3; end
        repeat (5) @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 6;
        @(negedge clk);
        while (!bus.valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("busy_start_lat", lat, 33);
        check("busy_start_q", bus.quotient, 14);
        check("busy_start_r", bus.remainder, 2);
        run_div(1'b0, 32'd9, 32'd3, lat, st);
        check("after_q", bus.quotient, 3);
        check("after_r", bus.remainder, 0);

        // async reset mid-divide
        run_div(1'b0, 32'd100, 32'd7, lat, st);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd50; bus.b = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_q", bus.quotient, 0);
        check("arst_r", bus.remainder, 0);
        check("arst_stall", bus.stall, 0);
        check("arst_valid", bus.valid, 0);
        @(negedge clk) rst_n = 1'b1;
        watch_no_valid(40, seen);
        check("arst_no_valid", seen, 0);

        // random sweep against a 64-bit reference
        for (int i = 0; i < 1500; i++) begin
            sg = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 20));
                1: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (i % 97 == 0) rb = '0;
            sa = sg ? longint'($signed(ra)) : longint'(ra);
            sb = sg ? longint'($signed(rb)) : longint'(rb);
            eq = (rb == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
            er = (rb == 0) ? ra : 32'(sa % sb);
            run_div(sg, ra, rb, lat, st);
            check("rnd_q", bus.quotient, eq);
            check("rnd_r", bus.remainder, er);
            check("rnd_dbz", bus.div_by_zero, rb == 0);
            if (rb != 0) check("rnd_identity", 32'(bus.quotient * rb + bus.remainder), ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
